// File: rtl/scalar_wb_arbiter_if.sv
// Scalar write-back arbiter bus bundle.
// Groups the ALU result port, the load result port, the issue port, the
// busy scoreboard and the register-file write port.
//   master : producer/consumer side (drives *_vld, *_dst, *_data, iss_*)
//   slave  : arbiter side (drives *_rdy, busy, wr_*)
interface scalar_wb_arbiter_if;
    localparam int unsigned DST_W  = 4;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned NREG   = 16;

    logic              alu_vld;
    logic [DST_W-1:0]  alu_dst;
    logic [DATA_W-1:0] alu_data;
    logic              alu_rdy;

    logic              ld_vld;
    logic [DST_W-1:0]  ld_dst;
    logic [DATA_W-1:0] ld_data;
    logic              ld_rdy;

    logic              iss_en;
    logic [DST_W-1:0]  iss_dst;
    logic [NREG-1:0]   busy;

    logic              wr_en;
    logic [DST_W-1:0]  wr_dst;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output alu_vld, alu_dst, alu_data,
        output ld_vld, ld_dst, ld_data,
        output iss_en, iss_dst,
        input  alu_rdy, ld_rdy, busy,
        input  wr_en, wr_dst, wr_data
    );

    modport slave (
        input  alu_vld, alu_dst, alu_data,
        input  ld_vld, ld_dst, ld_data,
        input  iss_en, iss_dst,
        output alu_rdy, ld_rdy, busy,
        output wr_en, wr_dst, wr_data
    );
endinterface

// File: rtl/scalar_wb_arbiter.sv
// Scalar register-file write-back arbiter.
// Merges a FIFO-buffered ALU result stream and a single-entry load holding
// register onto one register-file write port. Loads have priority, but after
// MAX_LD_STREAK load grants while ALU results are waiting, the ALU is forced
// one grant. A per-register busy scoreboard tracks issued-but-unwritten
// destinations.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : scalar_wb_arbiter_if.slave (ALU/load inputs, issue, busy, wr_*)
module scalar_wb_arbiter #(
    parameter int unsigned FIFO_DEPTH    = 2,
    parameter int unsigned MAX_LD_STREAK = 2
) (
    input  logic               clk,
    input  logic               rst,
    scalar_wb_arbiter_if.slave bus
);

    localparam int unsigned DST_W  = 4;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned NREG   = 16;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned STRK_W = (MAX_LD_STREAK > 0) ? $clog2(MAX_LD_STREAK + 1) : 1;

    typedef struct packed {
        logic [DST_W-1:0]  dst;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        LD_PRI,
        ALU_FORCE
    } arb_state_e;

    // State
    arb_state_e        state, state_d;
    wb_entry_t         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, count_d;
    logic              ld_full;
    wb_entry_t         ld_entry;
    logic [STRK_W-1:0] streak, streak_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic              wr_en_q;
    logic [DST_W-1:0]  wr_dst_q;
    logic [DATA_W-1:0] wr_data_q;

    // Combinational decisions
    logic              fifo_ne;
    logic              alu_push;
    logic              ld_push;
    logic              grant_ld;
    logic              grant_alu;
    logic              grant_any;
    wb_entry_t         grant_entry;
    logic [NREG-1:0]   clr_mask;
    logic [NREG-1:0]   set_mask;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Ready flags come from registered occupancy only: a full FIFO never
    // accepts, even when its head is popped in the same cycle.
    assign bus.alu_rdy = (count < CNT_W'(FIFO_DEPTH));
    assign bus.ld_rdy  = ~ld_full;
    assign bus.busy    = busy_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_dst  = wr_dst_q;
    assign bus.wr_data = wr_data_q;

    assign fifo_ne  = (count != '0);
    assign alu_push = bus.alu_vld & bus.alu_rdy;
    assign ld_push  = bus.ld_vld & ~ld_full;

    // Arbiter next-state, grant selection and streak tracking
    always_comb begin
        state_d   = state;
        streak_d  = streak;
        grant_ld  = 1'b0;
        grant_alu = 1'b0;

        unique case (state)
            LD_PRI: begin
                if (ld_full) begin
                    grant_ld = 1'b1;
                end else if (fifo_ne) begin
                    grant_alu = 1'b1;
                end
            end
            ALU_FORCE: begin
                if (fifo_ne) begin
                    grant_alu = 1'b1;
                end else if (ld_full) begin
                    grant_ld = 1'b1;
                end
                state_d = LD_PRI;
            end
            default: state_d = LD_PRI;
        endcase

        // Streak only measures loads that overtook waiting ALU results.
        if (grant_alu || !fifo_ne) begin
            streak_d = '0;
        end else if (grant_ld && (streak != STRK_W'(MAX_LD_STREAK))) begin
            streak_d = streak + STRK_W'(1);
        end

        if ((state == LD_PRI) && (streak_d >= STRK_W'(MAX_LD_STREAK))) begin
            state_d = ALU_FORCE;
        end
    end

    // Granted entry, FIFO occupancy and scoreboard update
    always_comb begin
        grant_any   = grant_ld | grant_alu;
        grant_entry = grant_ld ? ld_entry : fifo_mem[rd_ptr];
        count_d     = count + CNT_W'(alu_push) - CNT_W'(grant_alu);
        clr_mask    = grant_any  ? (NREG'(1) << grant_entry.dst) : '0;
        set_mask    = bus.iss_en ? (NREG'(1) << bus.iss_dst)     : '0;
        // Set is applied after clear so a same-edge issue keeps the bit.
        busy_d      = (busy_q & ~clr_mask) | set_mask;
    end

    // FIFO storage; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (!rst && alu_push) begin
            fifo_mem[wr_ptr] <= wb_entry_t'{dst: bus.alu_dst, data: bus.alu_data};
        end
    end

    // Control state, load register and write port
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LD_PRI;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ld_full   <= 1'b0;
            ld_entry  <= '0;
            streak    <= '0;
            busy_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_dst_q  <= '0;
            wr_data_q <= '0;
        end else begin
            state  <= state_d;
            streak <= streak_d;
            count  <= count_d;
            busy_q <= busy_d;

            if (alu_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (grant_alu) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end

            // A grant implies full, so capture and release never coincide.
            if (ld_push) begin
                ld_full  <= 1'b1;
                ld_entry <= wb_entry_t'{dst: bus.ld_dst, data: bus.ld_data};
            end else if (grant_ld) begin
                ld_full  <= 1'b0;
            end

            wr_en_q <= grant_any;
            if (grant_any) begin
                wr_dst_q  <= grant_entry.dst;
                wr_data_q <= grant_entry.data;
            end
        end
    end

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// Self-checking bench for scalar_wb_arbiter: a queue-based reference model
// checked every cycle, plus hand-computed literal checks on directed vectors.
module tb_scalar_wb_arbiter;

    localparam int unsigned DEPTH      = 2;
    localparam int unsigned MAX_STREAK = 2;

    typedef struct packed {
        logic [3:0]  dst;
        logic [15:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    scalar_wb_arbiter_if bus();

    scalar_wb_arbiter #(
        .FIFO_DEPTH    (DEPTH),
        .MAX_LD_STREAK (MAX_STREAK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model state
    ent_t        alu_q[$];
    ent_t        ld_q[$];
    int          m_streak;
    bit          m_force;
    logic [15:0] m_busy;
    logic        m_wr_en;
    logic [3:0]  m_wr_dst;
    logic [15:0] m_wr_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // One rising edge of the reference model, using the inputs held across it.
    task automatic model_edge();
        bit   fifo_ne;
        bit   ld_full;
        bit   alu_ok;
        bit   ld_ok;
        int   g;
        ent_t e;
        if (rst) begin
            alu_q.delete();
            ld_q.delete();
            m_streak  = 0;
            m_force   = 1'b0;
            m_busy    = '0;
            m_wr_en   = 1'b0;
            m_wr_dst  = '0;
            m_wr_data = '0;
        end else begin
            fifo_ne = (alu_q.size() != 0);
            ld_full = (ld_q.size() != 0);
            alu_ok  = (alu_q.size() < DEPTH);
            ld_ok   = !ld_full;
            g       = 0;
            e       = '0;
            if (m_force && fifo_ne)  g = 2;
            else if (ld_full)        g = 1;
            else if (fifo_ne)        g = 2;
            if (g == 1)      e = ld_q.pop_front();
            else if (g == 2) e = alu_q.pop_front();
            if (g == 1 && fifo_ne)        m_streak = m_streak + 1;
            else if (g == 2 || !fifo_ne)  m_streak = 0;
            m_force = !m_force && (m_streak >= MAX_STREAK);
            if (bus.alu_vld && alu_ok) alu_q.push_back({bus.alu_dst, bus.alu_data});
            if (bus.ld_vld && ld_ok)   ld_q.push_back({bus.ld_dst, bus.ld_data});
            if (g != 0) begin
                m_wr_en        = 1'b1;
                m_wr_dst       = e.dst;
                m_wr_data      = e.data;
                m_busy[e.dst]  = 1'b0;
            end else begin
                m_wr_en = 1'b0;
            end
            if (bus.iss_en) m_busy[bus.iss_dst] = 1'b1;
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("alu_rdy", 32'(bus.alu_rdy), 32'(alu_q.size() < DEPTH));
            chk("ld_rdy",  32'(bus.ld_rdy),  32'(ld_q.size() == 0));
            chk("busy",    32'(bus.busy),    32'(m_busy));
            chk("wr_en",   32'(bus.wr_en),   32'(m_wr_en));
            chk("wr_dst",  32'(bus.wr_dst),  32'(m_wr_dst));
            chk("wr_data", 32'(bus.wr_data), 32'(m_wr_data));
        end
    end

    task automatic idle();
        bus.alu_vld  = 1'b0;
        bus.alu_dst  = '0;
        bus.alu_data = '0;
        bus.ld_vld   = 1'b0;
        bus.ld_dst   = '0;
        bus.ld_data  = '0;
        bus.iss_en   = 1'b0;
        bus.iss_dst  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_alu(input logic [3:0] d, input logic [15:0] v);
        bus.alu_vld  = 1'b1;
        bus.alu_dst  = d;
        bus.alu_data = v;
    endtask

    task automatic set_ld(input logic [3:0] d, input logic [15:0] v);
        bus.ld_vld  = 1'b1;
        bus.ld_dst  = d;
        bus.ld_data = v;
    endtask

    task automatic set_iss(input logic [3:0] d);
        bus.iss_en  = 1'b1;
        bus.iss_dst = d;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state
        chk("rst_alu_rdy", 32'(bus.alu_rdy), 32'd1);
        chk("rst_ld_rdy",  32'(bus.ld_rdy),  32'd1);
        chk("rst_busy",    32'(bus.busy),    32'd0);
        chk("rst_wr_en",   32'(bus.wr_en),   32'd0);
        chk("rst_wr_dst",  32'(bus.wr_dst),  32'd0);
        chk("rst_wr_data", 32'(bus.wr_data), 32'd0);

        // Single ALU result: two-cycle input-to-write latency
        set_alu(4'd3, 16'h1234);
        tick();
        idle();
        chk("t1_e0_wr_en",   32'(bus.wr_en),   32'd0);
        tick();
        chk("t1_e1_wr_en",   32'(bus.wr_en),   32'd1);
        chk("t1_e1_wr_dst",  32'(bus.wr_dst),  32'd3);
        chk("t1_e1_wr_data", 32'(bus.wr_data), 32'h1234);
        tick();
        chk("t1_e2_wr_en",   32'(bus.wr_en),   32'd0);
        chk("t1_e2_hold",    32'(bus.wr_data), 32'h1234);

        // Load priority, FIFO full backpressure and ordering
        set_alu(4'd1, 16'hA001);
        set_ld(4'd8, 16'h8001);
        tick();
        idle();
        chk("t2_e0_wr_en",   32'(bus.wr_en),   32'd0);
        chk("t2_e0_ld_rdy",  32'(bus.ld_rdy),  32'd0);
        set_alu(4'd2, 16'hB002);
        tick();
        idle();
        chk("t2_e1_alu_rdy", 32'(bus.alu_rdy), 32'd0);
        chk("t2_e1_wr_dst",  32'(bus.wr_dst),  32'd8);
        chk("t2_e1_wr_data", 32'(bus.wr_data), 32'h8001);
        set_alu(4'd3, 16'hC003);
        set_ld(4'd9, 16'h9002);
        tick();
        idle();
        chk("t2_e2_alu_rdy", 32'(bus.alu_rdy), 32'd1);
        chk("t2_e2_wr_data", 32'(bus.wr_data), 32'hA001);
        set_alu(4'd3, 16'hC003);
        tick();
        idle();
        chk("t2_e3_wr_data", 32'(bus.wr_data), 32'h9002);
        chk("t2_e3_alu_rdy", 32'(bus.alu_rdy), 32'd0);
        tick();
        chk("t2_e4_wr_data", 32'(bus.wr_data), 32'hB002);
        tick();
        chk("t2_e5_wr_data", 32'(bus.wr_data), 32'hC003);
        tick();
        chk("t2_e6_wr_en",   32'(bus.wr_en),   32'd0);

        // Busy scoreboard: set, clear, same-edge set wins, register 0
        set_iss(4'd5);
        tick();
        idle();
        chk("t3_set",        32'(bus.busy),    32'h0020);
        set_alu(4'd5, 16'h5555);
        tick();
        idle();
        chk("t3_pending",    32'(bus.busy),    32'h0020);
        tick();
        chk("t3_wr_dst",     32'(bus.wr_dst),  32'd5);
        chk("t3_clear",      32'(bus.busy),    32'h0000);
        set_iss(4'd5);
        set_alu(4'd5, 16'h5A5A);
        tick();
        idle();
        chk("t3_reset_bit",  32'(bus.busy),    32'h0020);
        set_iss(4'd5);
        tick();
        idle();
        chk("t3_both_wr",    32'(bus.wr_data), 32'h5A5A);
        chk("t3_set_wins",   32'(bus.busy),    32'h0020);
        set_iss(4'd0);
        tick();
        idle();
        chk("t3_r0_set",     32'(bus.busy),    32'h0021);
        set_alu(4'd0, 16'h0000);
        tick();
        idle();
        tick();
        chk("t3_r0_clear",   32'(bus.busy),    32'h0020);

        // Reset in the middle of traffic
        for (int r = 4; r < 8; r++) begin
            set_iss(4'(r));
            tick();
        end
        idle();
        set_alu(4'd1, 16'h1111);
        set_ld(4'd8, 16'h8888);
        tick();
        idle();
        set_alu(4'd2, 16'h2222);
        tick();
        idle();
        chk("t4_pre_busy",    32'(bus.busy),    32'h00F0);
        chk("t4_pre_alu_rdy", 32'(bus.alu_rdy), 32'd0);
        rst = 1'b1;
        set_alu(4'd4, 16'h4444);
        set_ld(4'd6, 16'h6666);
        set_iss(4'd3);
        tick();
        rst = 1'b0;
        idle();
        chk("t4_busy",    32'(bus.busy),    32'd0);
        chk("t4_wr_en",   32'(bus.wr_en),   32'd0);
        chk("t4_wr_dst",  32'(bus.wr_dst),  32'd0);
        chk("t4_wr_data", 32'(bus.wr_data), 32'd0);
        chk("t4_alu_rdy", 32'(bus.alu_rdy), 32'd1);
        chk("t4_ld_rdy",  32'(bus.ld_rdy),  32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_no_wr", 32'(bus.wr_en), 32'd0);
        end

        // Mixed traffic against the model
        for (int i = 0; i < 300; i++) begin
            bus.alu_vld  = 1'($urandom_range(0, 1));
            bus.alu_dst  = 4'($urandom);
            bus.alu_data = 16'($urandom);
            bus.ld_vld   = ($urandom_range(0, 3) != 0);
            bus.ld_dst   = 4'($urandom);
            bus.ld_data  = 16'($urandom);
            bus.iss_en   = 1'($urandom_range(0, 1));
            bus.iss_dst  = 4'($urandom);
            tick();
        end
        idle();
        for (int i = 0; i < 6; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scalar_wb_arbiter.md
SCALAR_WB_ARBITER -- requirements
Module: scalar_wb_arbiter

Interface
REQ-001 Parameter: FIFO_DEPTH, default 2, ALU result FIFO depth; fixed at 2 for this release.
REQ-002 Parameter: MAX_LD_STREAK, default 2, consecutive load grants allowed while ALU FIFO non-empty.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 alu_vld  input  1  ALU result valid.
REQ-006 alu_dst  input  4  ALU destination scalar register.
REQ-007 alu_data  input  16  ALU result.
REQ-008 alu_rdy  output  1  ALU FIFO can accept.
REQ-009 ld_vld  input  1  load result valid.
REQ-010 ld_dst  input  4  load destination register.
REQ-011 ld_data  input  16  load data.
REQ-012 ld_rdy  output  1  load holding register empty.
REQ-013 iss_en  input  1  instruction issued that writes a scalar register.
REQ-014 iss_dst  input  4  destination of the issued instruction.
REQ-015 busy  output  16  per-register pending-write scoreboard.
REQ-016 wr_en  output  1  register file write enable, registered.
REQ-017 wr_dst  output  4  register file write address, registered.
REQ-018 wr_data  output  16  register file write data, registered.

Function
REQ-019 ALU path SHALL be a FIFO_DEPTH-entry FIFO; push on rising edge when alu_vld && alu_rdy.
REQ-020 alu_rdy SHALL equal (fifo count < FIFO_DEPTH) from registered count only; no bypass when full, even if a pop occurs the same cycle.
REQ-021 Load path SHALL be a 1-entry holding register; ld_rdy = ~ld_full; capture on ld_vld && ld_rdy.
REQ-022 Each cycle, arbiter SHALL select at most one stored entry: the load holding register or the FIFO head.
REQ-023 Arbiter FSM states: LD_PRI, ALU_FORCE.
REQ-024 LD_PRI: load full -> grant load; else FIFO non-empty -> grant ALU; else no grant.
REQ-025 Streak counter SHALL increment on each load grant while FIFO non-empty, and clear on any ALU grant or when FIFO is empty.
REQ-026 Transition LD_PRI -> ALU_FORCE when the streak counter reaches MAX_LD_STREAK.
REQ-027 ALU_FORCE: FIFO non-empty -> grant ALU and return to LD_PRI; if FIFO is empty, behave as LD_PRI and return to LD_PRI.
REQ-028 Granted entry SHALL be removed at the same edge, and wr_en/wr_dst/wr_data loaded with it; with no grant, wr_en = 0 and wr_dst/wr_data hold.
REQ-029 Latency: entry captured at edge k SHALL appear on wr_* after edge k+1 at the earliest (2 cycles input-to-write).
REQ-030 Simultaneous push and grant of the same storage (FIFO or load register) SHALL both take effect; count is unchanged for the FIFO; for the load register, the new data replaces the granted entry only if ld_rdy was high (i.e. never, since grant implies full).
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH; no overflow or underflow under any input sequence.
REQ-032 busy[r] SHALL be set at the edge where iss_en && iss_dst == r.
REQ-033 busy[r] SHALL be cleared at the edge where a grant loads wr_dst = r (the edge wr_en rises).
REQ-034 A set and a clear of the same r at the same edge SHALL leave busy[r] = 1 (set wins).
REQ-035 Register 0 SHALL receive no special treatment.

Reset
REQ-036 On rst = 1 at a rising edge: FIFO empty, pointers 0, load register empty, FSM = LD_PRI, streak = 0, busy = 0, wr_en = 0, wr_dst = 0, wr_data = 0.
REQ-037 rst SHALL override all same-cycle pushes, grants, and issues; any in-flight data is discarded.
REQ-038 After reset, alu_rdy = 1 and ld_rdy = 1 in the following cycle.

Verification
REQ-039 Single ALU: alu_vld, dst=3, data=0x1234 at edge 0 -> wr_en=1, wr_dst=3, wr_data=0x1234 after edge 1 only; alu_rdy never low.
REQ-040 Fairness: FIFO holds 2 entries; load stream continuous -> grants L,L,A,L,L,A...; both FIFO entries written within 6 cycles.
REQ-041 Backpressure: 3 back-to-back ALU results with no drain possible -> alu_rdy=0 after 2 pushes; third accepted only after a pop; order preserved.
REQ-042 Scoreboard: iss_en dst=5 -> busy[5]=1; later write dst=5 -> busy[5]=0; issue dst=5 on the same edge as write dst=5 -> busy[5] stays 1.
REQ-043 Reset mid-operation: FIFO=2, load full, busy=0x00F0, assert rst -> next cycle all outputs zero, alu_rdy=ld_rdy=1, no wr_en pulse afterwards.
